cache_ram_arbiter: RTL and testbench

Shares the single main-RAM port between two direct-mapped caches: requester 0 is the instruction cache and requester 1 is the data cache.
Accepts each cache's level-held fetch/flush request and arbitrates round-robin between the caches. Issues one RAM transaction at a time and returns a one-cycle fetch_ack/flush_ack with read data to the owning cache.
Sits between the cache fetch/flush handshake and the RAM controller.

---
 rtl/cache_ram_arbiter_if.sv | 50 +++++
 rtl/cache_ram_arbiter.sv | 148 ++++++++++++++
 tb/tb_cache_ram_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_ram_arbiter_if.sv
// Cache/RAM arbiter bundle: both cache request ports, the RAM port and status.
// slave = arbiter view, master = environment (caches + RAM) view.
interface cache_ram_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  c0_fetch;
  logic                  c0_flush;
  logic [ADDR_WIDTH-1:0] c0_addr;
  logic [DATA_WIDTH-1:0] c0_wdata;
  logic                  c0_fetch_ack;
  logic                  c0_flush_ack;
  logic [DATA_WIDTH-1:0] c0_rdata;
  logic                  c1_fetch;
  logic                  c1_flush;
  logic [ADDR_WIDTH-1:0] c1_addr;
  logic [DATA_WIDTH-1:0] c1_wdata;
  logic                  c1_fetch_ack;
  logic                  c1_flush_ack;
  logic [DATA_WIDTH-1:0] c1_rdata;
  logic                  ram_req;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_ack;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  busy;
  logic                  grant;
  logic                  err;

  modport slave (
    input  c0_fetch, c0_flush, c0_addr, c0_wdata,
    input  c1_fetch, c1_flush, c1_addr, c1_wdata,
    input  ram_ack, ram_rdata,
    output c0_fetch_ack, c0_flush_ack, c0_rdata,
    output c1_fetch_ack, c1_flush_ack, c1_rdata,
    output ram_req, ram_we, ram_addr, ram_wdata,
    output busy, grant, err
  );

  modport master (
    output c0_fetch, c0_flush, c0_addr, c0_wdata,
    output c1_fetch, c1_flush, c1_addr, c1_wdata,
    output ram_ack, ram_rdata,
    input  c0_fetch_ack, c0_flush_ack, c0_rdata,
    input  c1_fetch_ack, c1_flush_ack, c1_rdata,
    input  ram_req, ram_we, ram_addr, ram_wdata,
    input  busy, grant, err
  );
endinterface

// File: rtl/cache_ram_arbiter.sv
// Round-robin arbiter sharing one RAM port between I-cache (0) and D-cache (1).
// Define ARB_TIMEOUT_EN for an ISSUE watchdog that completes stuck transactions.
module cache_ram_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input logic                clka,
  input logic                rsta,
  cache_ram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_ACK,
    S_RELEASE
  } state_t;

  state_t                r_state;
  logic                  r_prio;
  logic                  r_grant;
  logic                  r_we;
  logic                  r_req;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rd0;
  logic [DATA_WIDTH-1:0] r_rd1;
  logic                  r_fe0_ack;
  logic                  r_fl0_ack;
  logic                  r_fe1_ack;
  logic                  r_fl1_ack;
  logic                  r_err;

  logic                  w_r0;
  logic                  w_r1;
  logic                  w_sel;
  logic                  w_sel_fl;
  logic                  w_tmo;
  logic                  w_done;
  logic [DATA_WIDTH-1:0] w_rd;

  assign w_r0     = bus.c0_fetch | bus.c0_flush;
  assign w_r1     = bus.c1_fetch | bus.c1_flush;
  // r_prio names the cache that wins a tie
  assign w_sel    = (w_r0 & w_r1) ? r_prio : w_r1;
  assign w_sel_fl = w_sel ? bus.c1_flush : bus.c0_flush;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_cnt;

  assign w_tmo = (r_state == S_ISSUE) && !bus.ram_ack &&
                 (r_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      r_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_cnt <= r_cnt + TW'(1);
    end else begin
      r_cnt <= '0;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  assign w_done = (r_state == S_ISSUE) &&
                  (bus.ram_ack || w_tmo);
  assign w_rd   = w_tmo ? '1 : bus.ram_rdata;

  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      r_state   <= S_IDLE;
      r_prio    <= 1'b0;
      r_grant   <= 1'b0;
      r_we      <= 1'b0;
      r_req     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rd0     <= '0;
      r_rd1     <= '0;
      r_fe0_ack <= 1'b0;
      r_fl0_ack <= 1'b0;
      r_fe1_ack <= 1'b0;
      r_fl1_ack <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_fe0_ack <= 1'b0;
      r_fl0_ack <= 1'b0;
      r_fe1_ack <= 1'b0;
      r_fl1_ack <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_r0 | w_r1) begin
            r_grant <= w_sel;
            r_prio  <= ~w_sel;
            r_we    <= w_sel_fl;
            r_addr  <= w_sel ? bus.c1_addr : bus.c0_addr;
            r_wdata <= w_sel ? bus.c1_wdata : bus.c0_wdata;
            r_req   <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_done) begin
            r_req   <= 1'b0;
            r_err   <= w_tmo;
            r_state <= S_ACK;
            unique case (1'b1)
              (r_we && r_grant):   r_fl1_ack <= 1'b1;
              (r_we && !r_grant):  r_fl0_ack <= 1'b1;
              (!r_we && r_grant): begin
                r_fe1_ack <= 1'b1;
                r_rd1     <= w_rd;
              end
              (!r_we && !r_grant): begin
                r_fe0_ack <= 1'b1;
                r_rd0     <= w_rd;
              end
            endcase
          end
        end
        S_ACK:     r_state <= S_RELEASE;
        S_RELEASE: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ram_req      = r_req;
  assign bus.ram_we       = r_we;
  assign bus.ram_addr     = r_addr;
  assign bus.ram_wdata    = r_wdata;
  assign bus.c0_fetch_ack = r_fe0_ack;
  assign bus.c0_flush_ack = r_fl0_ack;
  assign bus.c0_rdata     = r_rd0;
  assign bus.c1_fetch_ack = r_fe1_ack;
  assign bus.c1_flush_ack = r_fl1_ack;
  assign bus.c1_rdata     = r_rd1;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.grant        = r_grant;
  assign bus.err          = r_err;
endmodule

// File: tb/tb_cache_ram_arbiter.sv
// Self-checking bench for cache_ram_arbiter: directed plan plus random traffic
// checked against a request-level model of the arbitration rules.
`timescale 1ns/1ps
module tb_cache_ram_arbiter;
  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic clka = 1'b0;
  logic rsta = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  logic          pf [2];
  logic          pl [2];
  logic [AW-1:0] fadr [2];
  logic [AW-1:0] ladr [2];
  logic [DW-1:0] ldat [2];
  logic [DW-1:0] m_rd [2];
  logic          m_prio;

  cache_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef ARB_TIMEOUT_EN
  cache_ram_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (.clka(clka), .rsta(rsta), .bus(bus.slave));
`else
  cache_ram_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (.clka(clka), .rsta(rsta), .bus(bus.slave));
`endif

  always #5 clka = ~clka;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clka);
  endtask

  task automatic drive();
    bus.c0_fetch = pf[0];
    bus.c0_flush = pl[0];
    bus.c0_addr  = pl[0] ? ladr[0] : fadr[0];
    bus.c0_wdata = ldat[0];
    bus.c1_fetch = pf[1];
    bus.c1_flush = pl[1];
    bus.c1_addr  = pl[1] ? ladr[1] : fadr[1];
    bus.c1_wdata = ldat[1];
  endtask

  // Arbitration rule: lone requester wins, a tie goes to the cache not
  // served last, and a flush is served before a fetch of the same cache.
  task automatic pick(output int c, output logic we);
    logic r0, r1;
    r0 = pf[0] | pl[0];
    r1 = pf[1] | pl[1];
    if (r0 && r1) c = m_prio ? 1 : 0;
    else          c = r1 ? 1 : 0;
    m_prio = (c == 0);
    we = pl[c];
  endtask

  task automatic acks_vec(output logic [3:0] v);
    v = {bus.c1_flush_ack, bus.c1_fetch_ack,
         bus.c0_flush_ack, bus.c0_fetch_ack};
  endtask

  task automatic serve(input int lat, input logic [DW-1:0] rdat);
    int            c;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [3:0]    av, aexp;
    bit            seen, ok;
    pick(c, we);
    a    = we ? ladr[c] : fadr[c];
    wd   = ldat[c];
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = bus.ram_req;
    end
    chk("ram_req_seen", seen, 1);
    if (!seen) return;
    chk("grant", bus.grant, c);
    chk("ram_we", bus.ram_we, we);
    chk("ram_addr", bus.ram_addr, a);
    if (we) chk("ram_wdata", bus.ram_wdata, wd);
    chk("busy_issue", bus.busy, 1);
    bus.c0_addr  = AW'($urandom);
    bus.c1_addr  = AW'($urandom);
    bus.c0_wdata = $urandom;
    bus.c1_wdata = $urandom;
    ok = 1;
    for (int i = 0; i < lat; i++) begin
      tick();
      if (bus.ram_req !== 1'b1) ok = 0;
    end
    chk("ram_req_hold", ok, 1);
    chk("ram_addr_hold", bus.ram_addr, a);
    drive();
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = we ? $urandom : rdat;
    tick();
    bus.ram_ack   = 1'b0;
    bus.ram_rdata = $urandom;
    if (!we) m_rd[c] = rdat;
    aexp = 4'b0001 << (c * 2 + (we ? 1 : 0));
    acks_vec(av);
    chk("ack_pulse", av, aexp);
    chk("c0_rdata", bus.c0_rdata, m_rd[0]);
    chk("c1_rdata", bus.c1_rdata, m_rd[1]);
    chk("ram_req_drop", bus.ram_req, 0);
    chk("err_quiet", bus.err, 0);
    if (we) pl[c] = 1'b0;
    else    pf[c] = 1'b0;
    drive();
    tick();
    acks_vec(av);
    chk("ack_one_cycle", av, 0);
    chk("busy_release", bus.busy, 1);
    tick();
    chk("busy_idle", bus.busy, 0);
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic serve_tmo();
    int         c, n;
    logic       we;
    logic [3:0] av;
    bit         seen;
    pick(c, we);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = bus.ram_req;
    end
    chk("tmo_req_seen", seen, 1);
    n = 0;
    av = 0;
    while (av == 0 && n < 40) begin
      tick();
      n++;
      acks_vec(av);
    end
    chk("tmo_cycles", n, TMO);
    chk("tmo_err", bus.err, 1);
    chk("tmo_ram_req", bus.ram_req, 0);
    if (!we) m_rd[c] = '1;
    chk("tmo_c0_rdata", bus.c0_rdata, m_rd[0]);
    chk("tmo_c1_rdata", bus.c1_rdata, m_rd[1]);
    if (we) pl[c] = 1'b0;
    else    pf[c] = 1'b0;
    drive();
    tick();
    chk("tmo_err_pulse", bus.err, 0);
    tick();
    chk("tmo_idle", bus.busy, 0);
  endtask
`endif

  initial begin
    logic [3:0] av;
    bit         seen;
    for (int i = 0; i < 2; i++) begin
      pf[i] = 0; pl[i] = 0; fadr[i] = 0;
      ladr[i] = 0; ldat[i] = 0; m_rd[i] = 0;
    end
    m_prio = 1'b0;
    bus.ram_ack   = 1'b0;
    bus.ram_rdata = '0;
    drive();
    #2 rsta = 1'b0;
    tick();
    tick();
    acks_vec(av);
    chk("rst_acks", av, 0);
    chk("rst_ram_req", bus.ram_req, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_grant", bus.grant, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_c0_rdata", bus.c0_rdata, 0);
    chk("rst_c1_rdata", bus.c1_rdata, 0);
    rsta = 1'b1;
    tick();

    bus.ram_ack = 1'b1;
    tick();
    bus.ram_ack = 1'b0;
    tick();
    acks_vec(av);
    chk("stray_ack_acks", av, 0);
    chk("stray_ack_busy", bus.busy, 0);

    pf[0] = 1; fadr[0] = 12'd1000; drive();
    serve(10, 32'd1002003009);

    pl[1] = 1; ladr[1] = 0; ldat[1] = 32'd2123000123; drive();
    serve(3, 32'h0);

    for (int r = 0; r < 2; r++) begin
      pf[0] = 1; fadr[0] = AW'(100 + r);
      pf[1] = 1; fadr[1] = AW'(200 + r);
      drive();
      serve(2, $urandom);
      serve(1, $urandom);
    end

    pf[0] = 1; fadr[0] = 12'd5; drive();
    serve(0, $urandom);
    pf[0] = 1; fadr[0] = 12'd6;
    pf[1] = 1; fadr[1] = 12'd7; drive();
    serve(1, $urandom);
    serve(1, $urandom);

    pl[0] = 1; ladr[0] = 12'd1024; ldat[0] = 32'd998;
    pf[0] = 1; fadr[0] = 12'd0; drive();
    serve(2, $urandom);
    serve(2, 32'hCAFE_0001);

    pf[0] = 1; fadr[0] = 12'd11;
    pf[1] = 1; fadr[1] = 12'd22; drive();
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = bus.ram_req;
    end
    chk("pre_rst_req", seen, 1);
    tick();
    rsta = 1'b0;
    #1;
    acks_vec(av);
    chk("mid_rst_req", bus.ram_req, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_acks", av, 0);
    chk("mid_rst_grant", bus.grant, 0);
    m_prio  = 1'b0;
    m_rd[0] = '0;
    m_rd[1] = '0;
    tick();
    rsta = 1'b1;
    serve(2, $urandom);
    serve(2, $urandom);

`ifdef ARB_TIMEOUT_EN
    pf[0] = 1; fadr[0] = 12'd77; drive();
    serve_tmo();
    pl[1] = 1; ladr[1] = 12'd78; ldat[1] = 32'h1234; drive();
    serve_tmo();
`endif

    for (int it = 0; it < 30; it++) begin
      for (int c = 0; c < 2; c++) begin
        pf[c]   = 1'($urandom);
        pl[c]   = 1'($urandom);
        fadr[c] = AW'($urandom);
        ladr[c] = AW'($urandom);
        ldat[c] = $urandom;
      end
      if (!(pf[0] | pl[0] | pf[1] | pl[1])) pf[1] = 1;
      drive();
      while (pf[0] | pl[0] | pf[1] | pl[1])
        serve(int'($urandom_range(0, 6)), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
